// File: rtl/r5_bfly_seq.sv
// r5_bfly_seq -- sequencer around an external radix-5 butterfly datapath.
//
// Collects five complex single-precision samples, fires the datapath with a
// one-cycle dp_go, waits LATENCY cycles, captures the five results and
// streams them back out one sample per handshake. One butterfly in flight.
// Sample data is moved bit-exact; no arithmetic is performed on it.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_re/in_img         input sample (IEEE-754 single, real/imag)
//   in_valid/in_ready    input handshake
//   dp_x_re/dp_x_img     five operands to datapath, slot k = [32k+31:32k]
//   dp_go                one-cycle datapath start pulse
//   dp_y_re/dp_y_img     five datapath results, same packing as dp_x
//   out_re/out_img       output sample
//   out_valid/out_ready  output handshake
//   out_last             marks slot 4 of each frame
//   busy                 high whenever not loading operands
//   frame_cnt            completed frames, wraps modulo 2^FCW
module r5_bfly_seq #(
   parameter int unsigned LATENCY = 24,
   parameter int unsigned FCW     = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [31:0]    in_re,
   input  logic [31:0]    in_img,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [159:0]   dp_x_re,
   output logic [159:0]   dp_x_img,
   output logic           dp_go,
   input  logic [159:0]   dp_y_re,
   input  logic [159:0]   dp_y_img,
   output logic [31:0]    out_re,
   output logic [31:0]    out_img,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic           busy,
   output logic [FCW-1:0] frame_cnt
);

   typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [2:0]     idx, odx;
   logic [7:0]     cnt;
   logic [FCW-1:0] fcnt;
   logic [159:0]   x_re, x_img, y_re, y_img;
   logic           in_xfer, out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD:  if (in_xfer && idx == 3'd4)   state_nxt = ISSUE;
         ISSUE:                               state_nxt = WAIT;
         WAIT:  if (cnt == 8'd0)              state_nxt = DRAIN;
         DRAIN: if (out_xfer && odx == 3'd4)  state_nxt = LOAD;
         default:                             state_nxt = LOAD;
      endcase
   end

   // Outputs. in_ready is gated by rst because LOAD is also the reset state.
   always_comb begin
      in_ready  = (state == LOAD) && !rst;
      dp_go     = (state == ISSUE);
      out_valid = (state == DRAIN);
      out_last  = (state == DRAIN) && (odx == 3'd4);
      busy      = (state != LOAD);
   end

   // Operand/result buffers, slot indices, latency counter, frame counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         odx   <= '0;
         cnt   <= '0;
         fcnt  <= '0;
         x_re  <= '0;
         x_img <= '0;
         y_re  <= '0;
         y_img <= '0;
      end else begin
         if (in_xfer) begin
            for (int unsigned k = 0; k < 5; k++) begin
               if (idx == 3'(k)) begin
                  x_re[32*k +: 32]  <= in_re;
                  x_img[32*k +: 32] <= in_img;
               end
            end
            idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
         end

         // Counter reaches 0 in the LATENCY-th cycle after ISSUE.
         if (state == ISSUE)
            cnt <= 8'(LATENCY - 1);
         else if (state == WAIT && cnt != 8'd0)
            cnt <= cnt - 8'd1;

         if (state == WAIT && cnt == 8'd0) begin
            y_re  <= dp_y_re;
            y_img <= dp_y_img;
         end

         if (out_xfer) begin
            odx <= (odx == 3'd4) ? 3'd0 : odx + 3'd1;
            if (odx == 3'd4)
               fcnt <= fcnt + FCW'(1);
         end
      end
   end

   // Output slot select
   always_comb begin
      out_re  = '0;
      out_img = '0;
      for (int unsigned k = 0; k < 5; k++) begin
         if (odx == 3'(k)) begin
            out_re  = y_re[32*k +: 32];
            out_img = y_img[32*k +: 32];
         end
      end
   end

   assign dp_x_re   = x_re;
   assign dp_x_img  = x_img;
   assign frame_cnt = fcnt;

endmodule

// File: tb/tb_r5_bfly_seq.sv
// Bench for r5_bfly_seq: two instances (LATENCY=24/FCW=16 and
// LATENCY=1/FCW=2), each with a loopback datapath model and a scoreboard.
module tb_r5_bfly_seq;

   typedef struct packed {
      logic [31:0] re;
      logic [31:0] im;
      logic        last;
   } exp_t;

   int nvec = 0;
   int nbad = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
      nvec++;
      if (act !== req) begin
         nbad++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'h7FC0_0001;  // NaN with payload
         1:       return 32'hFF80_0000;  // -Inf
         2:       return 32'h8000_0000;  // -0
         default: return $urandom();
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int unsigned L  = (g == 0) ? 24 : 1;
      localparam int unsigned FC = (g == 0) ? 16 : 2;

      logic          rst = 1'b1;
      logic [31:0]   in_re = '0, in_img = '0;
      logic          in_valid = 1'b0;
      logic          in_ready, dp_go, out_valid, out_last, busy;
      logic [159:0]  dp_x_re, dp_x_img;
      logic [159:0]  dp_y_re = '0, dp_y_img = '0;
      logic [31:0]   out_re, out_img;
      logic          out_ready = 1'b1;
      logic [FC-1:0] frame_cnt;

      r5_bfly_seq #(.LATENCY(L), .FCW(FC)) dut (
         .clk(clk), .rst(rst),
         .in_re(in_re), .in_img(in_img), .in_valid(in_valid), .in_ready(in_ready),
         .dp_x_re(dp_x_re), .dp_x_img(dp_x_img), .dp_go(dp_go),
         .dp_y_re(dp_y_re), .dp_y_img(dp_y_img),
         .out_re(out_re), .out_img(out_img), .out_valid(out_valid), .out_ready(out_ready),
         .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
      );

      // Reference model state
      exp_t         exq[$];
      logic [31:0]  ops_re[$], ops_im[$];
      int           exp_fc = 0;
      int           cyc = 0, go_cyc = 0, n_go = 0, hold = 0, mode = 0;
      bit           go_pend = 0, in_frame = 0, fc_chk = 0, prev_hold = 0, prev_ov = 0, fin = 0;
      logic [159:0] st_re, st_im, er, ei;
      logic [31:0]  prev_re, prev_im;
      int           slot = 0;

      // Monitor, datapath loopback model and out_ready driver
      always @(negedge clk) begin
         cyc++;
         if (!rst) begin
            case (mode)
               0: out_ready = 1'b1;
               1: out_ready = ($urandom_range(0, 2) != 0);
               default: begin
                  if (out_valid && slot == 2 && hold < 7) begin
                     out_ready = 1'b0;
                     hold++;
                  end else out_ready = 1'b1;
               end
            endcase

            if (fc_chk) begin
               chk("frame_cnt", frame_cnt, exp_fc);
               chk("in_ready_after_frame", in_ready, 1);
               chk("busy_after_frame", busy, 0);
               fc_chk = 0;
            end

            if (in_frame) begin
               chk("in_ready_busy_in_frame", {in_ready, busy}, 2'b01);
               chk("dp_x_re_stable", dp_x_re, st_re);
               chk("dp_x_img_stable", dp_x_img, st_im);
            end else begin
               chk("out_valid_idle", out_valid, 0);
            end

            if (dp_go) begin
               chk("ops_before_go", ops_re.size(), 5);
               er = '0;
               ei = '0;
               for (int k = 0; k < 5 && k < ops_re.size(); k++) begin
                  er[32*k +: 32] = ops_re[k];
                  ei[32*k +: 32] = ops_im[k];
               end
               chk("dp_x_re", dp_x_re, er);
               chk("dp_x_img", dp_x_img, ei);
               chk("in_ready_at_go", {in_ready, busy}, 2'b01);
               ops_re.delete();
               ops_im.delete();
               st_re = dp_x_re;
               st_im = dp_x_img;
               go_cyc = cyc;
               go_pend = 1;
               in_frame = 1;
               n_go++;
            end

            // Results are only present in the cycle the DUT should sample them.
            if (go_pend && cyc == go_cyc + int'(L)) begin
               dp_y_re = st_re;
               dp_y_img = st_im;
               go_pend = 0;
            end else begin
               for (int k = 0; k < 5; k++) begin
                  dp_y_re[32*k +: 32] = $urandom();
                  dp_y_img[32*k +: 32] = $urandom();
               end
            end

            if (out_valid && !prev_ov)
               chk("out_valid_rise_cycle", cyc, go_cyc + int'(L) + 1);

            if (prev_hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", {out_re, out_img}, {prev_re, prev_im});
            end
            prev_hold = out_valid && !out_ready;
            prev_re = out_re;
            prev_im = out_img;

            if (out_valid && out_ready) begin
               chk("output_expected", exq.size() != 0, 1);
               if (exq.size() != 0) begin
                  exp_t e;
                  e = exq.pop_front();
                  chk("out_re", out_re, e.re);
                  chk("out_img", out_img, e.im);
                  chk("out_last", out_last, e.last);
                  slot = (slot + 1) % 5;
                  if (e.last) begin
                     exp_fc = (exp_fc + 1) % (1 << FC);
                     fc_chk = 1;
                     in_frame = 0;
                     hold = 0;
                  end
               end
            end
            prev_ov = out_valid;
         end else begin
            prev_ov = 0;
            prev_hold = 0;
            fc_chk = 0;
         end
      end

      task automatic check_reset();
         chk("rst_in_ready", in_ready, 0);
         chk("rst_dp_go", dp_go, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_busy", busy, 0);
         chk("rst_frame_cnt", frame_cnt, 0);
         chk("rst_dp_x_re", dp_x_re, 0);
         chk("rst_dp_x_img", dp_x_img, 0);
         chk("rst_out", {out_re, out_img}, 0);
      endtask

      task automatic send(input logic [31:0] re, input logic [31:0] im, input int gaps);
         int   tries = 0;
         exp_t e;
         repeat (gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_re = re;
         in_img = im;
         while (!in_ready && tries < 3000) begin
            @(negedge clk);
            tries++;
         end
         if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            return;
         end
         e.re = re;
         e.im = im;
         e.last = (ops_re.size() == 4);
         exq.push_back(e);
         ops_re.push_back(re);
         ops_im.push_back(im);
      endtask

      // kind 0: 1.0..5.0 real, 0 imag; kind 1: random incl. NaN/Inf/-0.
      // gmode 0: no gaps; 1: 1,0,0 valid pattern; 2: random gaps.
      task automatic send_frame(input int kind, input int gmode, input bit drop);
         logic [31:0] re, im;
         int          gaps;
         for (int k = 0; k < 5; k++) begin
            case (k)
               0: re = 32'h3F80_0000;
               1: re = 32'h4000_0000;
               2: re = 32'h4040_0000;
               3: re = 32'h4080_0000;
               default: re = 32'h40A0_0000;
            endcase
            im = '0;
            if (kind != 0) begin
               re = rnd_val();
               im = rnd_val();
            end
            gaps = (gmode == 0) ? 0 : (gmode == 1) ? ((k == 0) ? 0 : 2) : int'($urandom_range(0, 3));
            send(re, im, gaps);
         end
         if (drop) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
      endtask

      task automatic wait_drain();
         int t = 0;
         while ((exq.size() != 0 || in_frame) && t < 5000) begin
            @(negedge clk);
            t++;
         end
         chk("drain_timeout", t < 5000, 1);
         repeat (2) @(negedge clk);
      endtask

      initial begin
         int n0, t;
         @(negedge clk);
         #1 check_reset();
         repeat (2) @(negedge clk);
         rst = 1'b0;
         #1 chk("in_ready_after_rst", in_ready, 1);

         send_frame(0, 0, 1);
         wait_drain();
         send_frame(1, 1, 1);
         wait_drain();
         mode = 2;
         send_frame(1, 0, 1);
         wait_drain();
         mode = 0;
         for (int f = 0; f < 3; f++) send_frame(1, 0, 0);
         @(negedge clk);
         in_valid = 1'b0;
         wait_drain();

         // Abort mid-WAIT (L=24) or mid-DRAIN (L=1)
         n0 = n_go;
         send_frame(1, 0, 1);
         t = 0;
         while (n_go == n0 && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("go_timeout", n_go != n0, 1);
         repeat ((L > 10) ? 10 : 3) @(negedge clk);
         #2 rst = 1'b1;
         exq.delete();
         ops_re.delete();
         ops_im.delete();
         go_pend = 0;
         in_frame = 0;
         exp_fc = 0;
         slot = 0;
         hold = 0;
         #1 check_reset();
         repeat (2) @(negedge clk);
         rst = 1'b0;

         send_frame(1, 0, 1);
         wait_drain();
         mode = 1;
         send_frame(1, 2, 1);
         send_frame(1, 2, 1);
         wait_drain();
         mode = 0;
         fin = 1;
      end
   end

   initial begin
      int t = 0;
      while (!(inst[0].fin && inst[1].fin) && t < 50000) begin
         @(negedge clk);
         t++;
      end
      chk("global_timeout", {inst[0].fin, inst[1].fin}, 2'b11);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
